// File: rtl/pomdp_env_stepper.sv
// POMDP environment stepper: samples s' and o from Q0.16 tables by cumulative scan against two LFSRs.
// Latency: accept -> step_valid in N_STATE+N_OBS+1 cycles; one action in flight, act_ready low while busy.
module pomdp_env_stepper #(
  parameter int N_STATE  = 2,
  parameter int N_ACT    = 3,
  parameter int N_OBS    = 2,
  parameter int REWARD_W = 32,
  localparam int SW   = (N_STATE > 1) ? $clog2(N_STATE) : 1,
  localparam int AW   = (N_ACT > 1) ? $clog2(N_ACT) : 1,
  localparam int OW   = (N_OBS > 1) ? $clog2(N_OBS) : 1,
  localparam int NMAX = (N_STATE > N_OBS) ? N_STATE : N_OBS,
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SW-1:0]       initial_state,
  input  logic [15:0]         seed0,
  input  logic [15:0]         seed1,
  input  logic [15:0]         trans      [N_ACT][N_STATE][N_STATE],
  input  logic [15:0]         observe    [N_ACT][N_STATE][N_OBS],
  input  logic [15:0]         vec_reward [N_ACT][N_STATE],
  input  logic                act_valid,
  input  logic [AW-1:0]       action,
  output logic                act_ready,
  output logic                step_valid,
  output logic                step_err,
  output logic [SW-1:0]       cur_state,
  output logic [OW-1:0]       observation,
  output logic [REWARD_W-1:0] reward,
  output logic [15:0]         step_count
);

  typedef enum logic [2:0] {IDLE, READY, TSCAN, OSCAN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       sel_q, sel_d;
  logic                found_q, found_d;
  logic [16:0]         c_q, c_d;
  logic [AW-1:0]       act_q, act_d;
  logic [SW-1:0]       nxt_s_q, nxt_s_d;
  logic [SW-1:0]       cur_state_q, cur_state_d;
  logic [OW-1:0]       obs_q, obs_d;
  logic [REWARD_W-1:0] reward_q, reward_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         lfsr0_q, lfsr0_d;
  logic [15:0]         lfsr1_q, lfsr1_d;
  logic                step_err_q, step_err_d;

  logic                accept, legal, last_t, last_o, hit;
  logic [15:0]         p, u;
  logic [16:0]         c_add;
  logic [CW-1:0]       sel_fin;
  logic [REWARD_W:0]   rsum;
  logic [REWARD_W-1:0] rsat;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign legal  = {1'b0, action} < (AW+1)'(N_ACT);
  assign accept = act_valid && act_ready;
  assign last_t = (idx_q == CW'(N_STATE - 1));
  assign last_o = (idx_q == CW'(N_OBS - 1));

  // One shared scan datapath; the table and LFSR are chosen by the active scan.
  always_comb begin
    p = 16'h0000;
    u = lfsr1_q;
    if (state_q == TSCAN) begin
      p = trans[act_q][cur_state_q][idx_q[SW-1:0]];
      u = lfsr0_q;
    end else begin
      p = observe[act_q][nxt_s_q][idx_q[OW-1:0]];
    end
    c_add   = c_q + ((p == 16'hFFFF) ? 17'h10000 : {1'b0, p});
    hit     = !found_q && ({1'b0, u} < c_add);
    // On the last cycle either this index hits or nothing did; both select it.
    sel_fin = found_q ? sel_q : idx_q;
    rsum    = {1'b0, reward_q} + {{(REWARD_W-15){1'b0}}, vec_reward[action][cur_state_q]};
    rsat    = rsum[REWARD_W] ? {REWARD_W{1'b1}} : rsum[REWARD_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = READY;
    end else begin
      case (state_q)
        READY:   if (accept && legal) state_d = TSCAN;
        TSCAN:   if (last_t) state_d = OSCAN;
        OSCAN:   if (last_o) state_d = DONE;
        DONE:    state_d = READY;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    act_ready  = (state_q == READY);
    step_valid = (state_q == DONE);
  end

  always_comb begin
    idx_d       = idx_q;
    sel_d       = sel_q;
    found_d     = found_q;
    c_d         = c_q;
    act_d       = act_q;
    nxt_s_d     = nxt_s_q;
    cur_state_d = cur_state_q;
    obs_d       = obs_q;
    reward_d    = reward_q;
    cnt_d       = cnt_q;
    lfsr0_d     = lfsr0_q;
    lfsr1_d     = lfsr1_q;
    step_err_d  = 1'b0;
    if (en) begin
      cur_state_d = initial_state;
      obs_d       = '0;
      reward_d    = '0;
      cnt_d       = '0;
      lfsr0_d     = (seed0 == 16'h0000) ? 16'h0001 : seed0;
      lfsr1_d     = (seed1 == 16'h0000) ? 16'h0001 : seed1;
      idx_d       = '0;
      c_d         = '0;
      found_d     = 1'b0;
    end else begin
      step_err_d = accept && !legal;
      case (state_q)
        READY: begin
          if (accept && legal) begin
            act_d    = action;
            reward_d = rsat;
            idx_d    = '0;
            c_d      = '0;
            found_d  = 1'b0;
          end
        end
        TSCAN, OSCAN: begin
          c_d   = c_add;
          idx_d = idx_q + CW'(1);
          if (hit) begin
            found_d = 1'b1;
            sel_d   = idx_q;
          end
          if (state_q == TSCAN && last_t) begin
            nxt_s_d = sel_fin[SW-1:0];
            lfsr0_d = lfsr_step(lfsr0_q);
            idx_d   = '0;
            c_d     = '0;
            found_d = 1'b0;
          end
          if (state_q == OSCAN && last_o) begin
            obs_d       = sel_fin[OW-1:0];
            cur_state_d = nxt_s_q;
            cnt_d       = cnt_q + 16'd1;
            lfsr1_d     = lfsr_step(lfsr1_q);
            idx_d       = '0;
            c_d         = '0;
            found_d     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      sel_q       <= '0;
      found_q     <= 1'b0;
      c_q         <= '0;
      act_q       <= '0;
      nxt_s_q     <= '0;
      cur_state_q <= '0;
      obs_q       <= '0;
      reward_q    <= '0;
      cnt_q       <= '0;
      lfsr0_q     <= 16'h0001;
      lfsr1_q     <= 16'h0001;
      step_err_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      found_q     <= found_d;
      c_q         <= c_d;
      act_q       <= act_d;
      nxt_s_q     <= nxt_s_d;
      cur_state_q <= cur_state_d;
      obs_q       <= obs_d;
      reward_q    <= reward_d;
      cnt_q       <= cnt_d;
      lfsr0_q     <= lfsr0_d;
      lfsr1_q     <= lfsr1_d;
      step_err_q  <= step_err_d;
    end
  end

  assign step_err    = step_err_q;
  assign cur_state   = cur_state_q;
  assign observation = obs_q;
  assign reward      = reward_q;
  assign step_count  = cnt_q;

endmodule

// File: tb/tb_pomdp_env_stepper.sv
// Bench for pomdp_env_stepper: directed phases plus random steps against a table-walking reference model.
`timescale 1ns/1ps
module tb_pomdp_env_stepper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [0:0]  initial_state;
  logic [15:0] seed0, seed1;
  logic [15:0] trans      [3][2][2];
  logic [15:0] observe    [3][2][2];
  logic [15:0] vec_reward [3][2];
  logic        act_valid;
  logic [1:0]  action;
  logic        act_ready, step_valid, step_err;
  logic [0:0]  cur_state, observation;
  logic [31:0] reward;
  logic [15:0] step_count;
  logic        act_ready16, step_valid16, step_err16;
  logic [0:0]  cur_state16, observation16;
  logic [15:0] reward16;
  logic [15:0] step_count16;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_state, m_obs, m_cnt;
  longint      m_rew;
  logic [15:0] m_l0, m_l1;

  always #5 clk = ~clk;

  pomdp_env_stepper u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .initial_state(initial_state),
    .seed0(seed0), .seed1(seed1), .trans(trans), .observe(observe),
    .vec_reward(vec_reward), .act_valid(act_valid), .action(action),
    .act_ready(act_ready), .step_valid(step_valid), .step_err(step_err),
    .cur_state(cur_state), .observation(observation), .reward(reward),
    .step_count(step_count)
  );

  pomdp_env_stepper #(.REWARD_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .initial_state(initial_state),
    .seed0(seed0), .seed1(seed1), .trans(trans), .observe(observe),
    .vec_reward(vec_reward), .act_valid(act_valid), .action(action),
    .act_ready(act_ready16), .step_valid(step_valid16), .step_err(step_err16),
    .cur_state(cur_state16), .observation(observation16), .reward(reward16),
    .step_count(step_count16)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int prob(input logic [15:0] v);
    return (v == 16'hFFFF) ? 65536 : int'(v);
  endfunction

  function automatic int pick_t(input int a, input int s, input logic [15:0] u);
    int c;
    c = 0;
    for (int j = 0; j < 2; j++) begin
      c += prob(trans[a][s][j]);
      if (int'(u) < c) return j;
    end
    return 1;
  endfunction

  function automatic int pick_o(input int a, input int s, input logic [15:0] u);
    int c;
    c = 0;
    for (int j = 0; j < 2; j++) begin
      c += prob(observe[a][s][j]);
      if (int'(u) < c) return j;
    end
    return 1;
  endfunction

  function automatic void model_en(input int init, input logic [15:0] s0, input logic [15:0] s1);
    m_state = init;
    m_obs   = 0;
    m_cnt   = 0;
    m_rew   = 0;
    m_l0    = (s0 == 0) ? 16'h0001 : s0;
    m_l1    = (s1 == 0) ? 16'h0001 : s1;
  endfunction

  function automatic void model_step(input int a);
    int sp;
    m_rew  += longint'(vec_reward[a][m_state]);
    sp      = pick_t(a, m_state, m_l0);
    m_obs   = pick_o(a, sp, m_l1);
    m_l0    = lfsr_next(m_l0);
    m_l1    = lfsr_next(m_l1);
    m_state = sp;
    m_cnt   = (m_cnt + 1) % 65536;
  endfunction

  function automatic logic [63:0] rew16_exp();
    return (m_rew > 65535) ? 64'd65535 : 64'(m_rew);
  endfunction

  task automatic rand_row(output logic [15:0] p0, output logic [15:0] p1);
    int a;
    a  = $urandom_range(0, 65535);
    p0 = 16'(a);
    p1 = (a == 0) ? 16'hFFFF : 16'(65536 - a);
  endtask

  task automatic do_en(input int init, input logic [15:0] s0, input logic [15:0] s1);
    en = 1'b1;
    initial_state = 1'(init);
    seed0 = s0;
    seed1 = s1;
    @(negedge clk);
    en = 1'b0;
    model_en(init, s0, s1);
    chk("en_ready", act_ready, 1);
    chk("en_state", cur_state, 64'(m_state));
    chk("en_reward", reward, 0);
    chk("en_count", step_count, 0);
  endtask

  task automatic do_step(input int a);
    int n;
    int lat;
    n = 0;
    while (!act_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_step", act_ready, 1);
    action = 2'(a);
    act_valid = 1'b1;
    @(negedge clk);
    act_valid = 1'b0;
    if (a >= 3) begin
      chk("err_pulse", step_err, 1);
      chk("err_ready", act_ready, 1);
      chk("err_state", cur_state, 64'(m_state));
      chk("err_reward", reward, 64'(m_rew));
      @(negedge clk);
      chk("err_clear", step_err, 0);
      return;
    end
    lat = 1;
    while (!step_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    model_step(a);
    chk("latency", 64'(lat), 5);
    chk("step_valid", step_valid, 1);
    chk("cur_state", cur_state, 64'(m_state));
    chk("observation", observation, 64'(m_obs));
    chk("reward", reward, 64'(m_rew));
    chk("reward16", reward16, rew16_exp());
    chk("step_count", step_count, 64'(m_cnt));
    @(negedge clk);
    chk("valid_pulse", step_valid, 0);
    chk("ready_after", act_ready, 1);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    en = 1'b0;
    act_valid = 1'b0;
    action = '0;
    initial_state = '0;
    seed0 = '0;
    seed1 = '0;
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 2; s++) begin
        rand_row(trans[a][s][0], trans[a][s][1]);
        rand_row(observe[a][s][0], observe[a][s][1]);
        vec_reward[a][s] = 16'($urandom_range(0, 65535));
      end

    // Reset values
    #22;
    chk("rst_state", cur_state, 0);
    chk("rst_obs", observation, 0);
    chk("rst_reward", reward, 0);
    chk("rst_count", step_count, 0);
    chk("rst_ready", act_ready, 0);
    chk("rst_valid", step_valid, 0);
    chk("rst_err", step_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Actions before en are ignored
    seen = 1'b0;
    act_valid = 1'b1;
    action = 2'd0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | act_ready | step_valid | step_err;
    end
    act_valid = 1'b0;
    chk("idle_ignores_action", seen, 0);
    chk("idle_count", step_count, 0);

    // Identity transition, deterministic observation, reward 6488
    trans[2][0][0] = 16'hFFFF; trans[2][0][1] = 16'h0000;
    trans[2][1][0] = 16'h0000; trans[2][1][1] = 16'hFFFF;
    observe[2][1][0] = 16'hFFFF; observe[2][1][1] = 16'h0000;
    vec_reward[2][1] = 16'd6488;
    do_en(1, 16'h1357, 16'h2468);
    do_step(2);
    chk("first_state", cur_state, 1);
    chk("first_reward", reward, 6488);
    chk("first_count", step_count, 1);
    for (int i = 1; i < 20; i++) begin
      do_step(2);
      chk("obs_zero", observation, 0);
    end
    chk("reward_20", reward, 129760);

    // Illegal action leaves everything alone
    do_step(3);
    do_step(2);

    // Abort on the 2nd TSCAN cycle
    action = 2'd2;
    act_valid = 1'b1;
    @(negedge clk);
    act_valid = 1'b0;
    @(negedge clk);
    en = 1'b1;
    initial_state = 1'b0;
    seed0 = 16'h0000;
    seed1 = 16'h5A5A;
    @(negedge clk);
    en = 1'b0;
    model_en(0, 16'h0000, 16'h5A5A);
    chk("abort_ready", act_ready, 1);
    chk("abort_valid", step_valid, 0);
    chk("abort_reward", reward, 0);
    chk("abort_state", cur_state, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | step_valid;
    end
    chk("abort_no_valid", seen, 0);
    for (int i = 0; i < 4; i++) do_step($urandom_range(0, 2));

    // Saturation of the 16-bit accumulator
    vec_reward[0][0] = 16'd7209;
    vec_reward[0][1] = 16'd7209;
    do_en(0, 16'hBEEF, 16'h0000);
    for (int i = 0; i < 10; i++) do_step(0);
    chk("rew16_sat", reward16, 65535);
    chk("rew32_nosat", reward, 72090);

    // Long random run with fair transitions
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 2; s++) begin
        trans[a][s][0] = 16'h8000;
        trans[a][s][1] = 16'h8000;
        rand_row(observe[a][s][0], observe[a][s][1]);
        vec_reward[a][s] = 16'($urandom_range(0, 65535));
      end
    do_en(1, 16'hA24B, 16'hC354);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 15) == 0) do_step(3);
      else do_step($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pomdp_env_stepper.md
Name: pomdp_env_stepper

Overview:
Parametrised POMDP environment stepper for the PBVI simulation flow. It generalises the fixed 2-state, 3-action, 2-observation environment to N_STATE states, N_ACT actions and N_OBS observations. It accepts an action from the decision logic through a valid/ready handshake, samples the next state and the observation from Q0.16 probability tables using two LFSRs, and accumulates reward. Its outputs feed the belief-update and decision stages.

Parameters:
N_STATE, 2, number of hidden states (2..16)
N_ACT, 3, number of actions (2..16)
N_OBS, 2, number of observations (2..16)
REWARD_W, 32, accumulated reward width (>=16)
SW/AW/OW, derived: $clog2 of N_STATE/N_ACT/N_OBS, minimum 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  episode start pulse
initial_state  in  SW  state loaded on en
seed0  in  16  transition LFSR seed, loaded on en
seed1  in  16  observation LFSR seed, loaded on en
trans  in  16 x [N_ACT][N_STATE][N_STATE]  P(s'|a,s), Q0.16
observe  in  16 x [N_ACT][N_STATE][N_OBS]  P(o|a,s'), Q0.16
vec_reward  in  16 x [N_ACT][N_STATE]  reward r(a,s), unsigned
act_valid  in  1  action offered
action  in  AW  offered action
act_ready  out  1  ready to accept an action
step_valid  out  1  one-cycle pulse: step result valid
step_err  out  1  one-cycle pulse: illegal action rejected
cur_state  out  SW  current hidden state
observation  out  OW  last sampled observation
reward  out  REWARD_W  accumulated reward
step_count  out  16  completed steps, wraps at 0xFFFF

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Under reset all outputs are 0, the FSM is IDLE, and both LFSRs hold 16'h0001.
- FSM states: IDLE, READY, TSCAN, OSCAN, DONE.
  - IDLE: act_ready=0. An en pulse moves the FSM to READY.
  - READY: act_ready=1.
  - TSCAN: transition scan, exactly N_STATE cycles.
  - OSCAN: observation scan, exactly N_OBS cycles.
  - DONE: step_valid=1 for one cycle, then READY.
- en, in any state and taking priority over everything else:
  - loads cur_state=initial_state, reward=0, step_count=0, observation=0;
  - loads seed0/seed1, with a zero seed replaced by 16'h0001;
  - aborts any scan in progress without a step_valid pulse; the next state is READY.
- Accept: act_valid && act_ready on a cycle.
  - Legal action (action < N_ACT): latch the action. reward += vec_reward[action][cur_state], using the pre-transition state. The addition saturates at 2^REWARD_W-1. Next state is TSCAN.
  - Illegal action (action >= N_ACT): step_err pulses the next cycle. No state, reward or LFSR change. The FSM stays READY.
- Sampling, the same method for both scans:
  - u = current LFSR value (16-bit).
  - Cumulative sum c is 17-bit and starts at 0. On scan cycle j, c += p[j], where an entry of 16'hFFFF counts as 17'h10000.
  - The first j with u < c is selected. If no index is selected, the last index is selected.
  - Scanning continues to the full length, so latency is fixed regardless of which index is selected.
  - TSCAN uses trans[a][cur_state][*] with LFSR0. OSCAN uses observe[a][s'][*] with LFSR1, where s' is the TSCAN result.
  - Each LFSR advances exactly once per step, at the end of its scan.
  - LFSR is a 16-bit Galois shift right, mask 16'hB400.
- DONE updates: cur_state=s', observation=o, step_count+1, all visible in the same cycle as step_valid.
- Latency: accept at cycle 0, step_valid at cycle N_STATE+N_OBS+1; act_ready is back at 1 the following cycle.
- Tables are sampled live during the scan and must be held stable from accept until step_valid.

Test Plan:
- Reset -> all outputs 0 and act_ready=0. Actions offered before en are never accepted.
- Defaults, en with initial_state=1, action=2, trans[2]=identity (16'hFFFF/0) -> cur_state=1, reward=6488, step_valid exactly 5 cycles after accept, step_count=1.
- observe[2][1]={16'hFFFF,0}, 20 back-to-back steps with action 2 -> observation=0 every step; reward=20*6488=129760.
- REWARD_W=16, vec_reward[0][*]=7209, 10 steps -> reward saturates at 65535.
- en asserted on the 2nd TSCAN cycle -> no step_valid, reward=0, cur_state=initial_state, act_ready=1 next cycle.
- Illegal action=3 with N_ACT=3 -> step_err one cycle later; cur_state, reward and the LFSRs are unchanged.
- Seeds 16'ha24b/16'hc354, trans 0.5/0.5, 1000 steps -> cur_state/observation sequence matches the bench LFSR reference model bit-exactly.
